// File: rtl/exe_div_unit_pkg.sv
// Shared types and constants for the EXE-stage divider.
// Contents: datapath width, iteration count, FSM state enum, result payload,
// and a helper that returns the magnitude of an operand.
package exe_div_unit_pkg;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned DIV_ITER = 32;
   localparam int unsigned CNT_W    = $clog2(DIV_ITER);
   localparam int unsigned CLZ_W    = $clog2(DATA_W) + 1;

   typedef enum logic [1:0] {
      DIV_IDLE,
      DIV_BUSY,
      DIV_DONE
   } DivStateType;

   typedef struct packed {
      logic [DATA_W-1:0] quot;
      logic [DATA_W-1:0] rem;
   } DivResultType;

   // Magnitude of a two's-complement value when is_signed, raw value otherwise.
   function automatic logic [DATA_W-1:0] div_abs(input logic [DATA_W-1:0] val,
                                                  input logic              is_signed);
      return (is_signed && val[DATA_W-1]) ? DATA_W'(-val) : val;
   endfunction

endpackage

// File: rtl/exe_div_unit_if.sv
// Divider request/response bundle between the EXE stage and the divider.
// master: pipeline side (drives start/operands/flush, sees busy/done/results).
// slave : divider side.
interface exe_div_unit_if;
   import exe_div_unit_pkg::*;

   logic              div_start;
   logic              div_signed;
   logic [DATA_W-1:0] div_a;
   logic [DATA_W-1:0] div_b;
   logic              div_flush;
   logic              div_busy;
   logic              div_done;
   logic [DATA_W-1:0] div_quot;
   logic [DATA_W-1:0] div_rem;

   modport master (
      output div_start, div_signed, div_a, div_b, div_flush,
      input  div_busy, div_done, div_quot, div_rem
   );

   modport slave (
      input  div_start, div_signed, div_a, div_b, div_flush,
      output div_busy, div_done, div_quot, div_rem
   );

endinterface

// File: rtl/exe_div_unit_clz32.sv
// div_clz32: combinational leading-zero count of a 32-bit value (0..32).
// Ports: val (in, 32), clz (out, 6).
// Only compiled when DIV_EARLY_OUT_EN is defined, since only the early-out
// build of exe_div_unit uses it.
`ifdef DIV_EARLY_OUT_EN
module div_clz32 (
   input  logic [31:0] val,
   output logic [5:0]  clz
);

   // Scan upward so the highest set bit wins.
   always_comb begin
      clz = 6'd32;
      for (int i = 0; i < 32; i++) begin
         if (val[i]) clz = 6'(31 - i);
      end
   end

endmodule
`endif

// File: rtl/exe_div_unit.sv
// exe_div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU in EXE.
// Ports:
//   clk, rst  - pipeline clock, asynchronous active-high reset
//   div_if    - slave side of exe_div_unit_if:
//               div_start/div_signed/div_a/div_b/div_flush in,
//               div_busy (combinational stall), div_done (pulse),
//               div_quot (to LO), div_rem (to HI) out.
// Configuration: define DIV_EARLY_OUT_EN to skip the leading-zero iterations
// of the dividend; results are identical, only latency changes.
module exe_div_unit
   import exe_div_unit_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   exe_div_unit_if.slave  div_if
);

   DivStateType       state;
   DivResultType      res_q;
   logic [DATA_W-1:0] rem_q;
   logic [DATA_W-1:0] quot_q;
   logic [DATA_W-1:0] dvsr_q;
   logic              sign_q_q;
   logic              sign_r_q;
   logic [CNT_W-1:0]  cnt_q;

   logic              start_ok_c;
   logic [DATA_W-1:0] abs_a_c;
   logic [DATA_W-1:0] abs_b_c;
   logic [CNT_W-1:0]  pre_shift_c;
   logic [DATA_W-1:0] init_quot_c;
   logic [DATA_W:0]   trial_c;
   logic              ge_c;
   logic [DATA_W-1:0] rem_nxt_c;
   logic [DATA_W-1:0] quot_nxt_c;
   logic [DATA_W-1:0] quot_fix_c;
   logic [DATA_W-1:0] rem_fix_c;
   logic              last_c;

   assign start_ok_c = (state == DIV_IDLE) && div_if.div_start && !div_if.div_flush;
   assign abs_a_c    = div_abs(div_if.div_a, div_if.div_signed);
   assign abs_b_c    = div_abs(div_if.div_b, div_if.div_signed);

   // Iterations to skip: the dividend's leading zeros (at least one iteration runs).
`ifdef DIV_EARLY_OUT_EN
   logic [CLZ_W-1:0] clz_c;

   div_clz32 u_clz (
      .val (abs_a_c),
      .clz (clz_c)
   );

   assign pre_shift_c = (clz_c == CLZ_W'(DATA_W)) ? CNT_W'(DATA_W - 1) : CNT_W'(clz_c);
`else
   assign pre_shift_c = '0;
`endif

   // Skipped iterations are accounted for by pre-loading the counter.
   assign init_quot_c = abs_a_c << pre_shift_c;

   // One restoring step: shift {rem,quot} left, subtract divisor when it fits.
   // The trial value needs one extra bit because a divisor above 2^31 can be
   // exceeded by the shifted remainder.
   assign trial_c    = {rem_q, quot_q[DATA_W-1]};
   assign ge_c       = trial_c >= {1'b0, dvsr_q};
   assign rem_nxt_c  = ge_c ? (trial_c[DATA_W-1:0] - dvsr_q) : trial_c[DATA_W-1:0];
   assign quot_nxt_c = {quot_q[DATA_W-2:0], ge_c};
   assign quot_fix_c = sign_q_q ? DATA_W'(-quot_nxt_c) : quot_nxt_c;
   assign rem_fix_c  = sign_r_q ? DATA_W'(-rem_nxt_c)  : rem_nxt_c;
   assign last_c     = (cnt_q == CNT_W'(DIV_ITER - 1));

   // Control FSM and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= DIV_IDLE;
         res_q    <= '0;
         rem_q    <= '0;
         quot_q   <= '0;
         dvsr_q   <= '0;
         sign_q_q <= 1'b0;
         sign_r_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         case (state)
            DIV_IDLE: begin
               if (start_ok_c) begin
                  if (div_if.div_b == '0) begin
                     // Divide by zero finishes immediately with raw dividend as remainder.
                     state <= DIV_DONE;
                     res_q <= '{quot: '1, rem: div_if.div_a};
                  end else begin
                     state    <= DIV_BUSY;
                     rem_q    <= '0;
                     quot_q   <= init_quot_c;
                     dvsr_q   <= abs_b_c;
                     sign_q_q <= div_if.div_signed &
                                 (div_if.div_a[DATA_W-1] ^ div_if.div_b[DATA_W-1]);
                     sign_r_q <= div_if.div_signed & div_if.div_a[DATA_W-1];
                     cnt_q    <= pre_shift_c;
                  end
               end
            end
            DIV_BUSY: begin
               if (div_if.div_flush) begin
                  state <= DIV_IDLE;
               end else begin
                  rem_q  <= rem_nxt_c;
                  quot_q <= quot_nxt_c;
                  cnt_q  <= cnt_q + CNT_W'(1);
                  if (last_c) begin
                     state <= DIV_DONE;
                     res_q <= '{quot: quot_fix_c, rem: rem_fix_c};
                  end
               end
            end
            DIV_DONE: begin
               state <= DIV_IDLE;
            end
            default: begin
               state <= DIV_IDLE;
            end
         endcase
      end
   end

   // Stall also covers the start cycle so the pipeline freezes at once.
   assign div_if.div_busy = start_ok_c || (state == DIV_BUSY);
   assign div_if.div_done = (state == DIV_DONE);
   assign div_if.div_quot = res_q.quot;
   assign div_if.div_rem  = res_q.rem;

endmodule

// File: tb/tb_exe_div_unit.sv
// Self-checking bench for exe_div_unit: directed corner cases plus random
// operations, checked by a scoreboard against an arithmetic reference model.
module tb_exe_div_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      int          cyc;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] last_q = '0;
   logic [31:0] last_r = '0;

   exe_div_unit_if dif();

   exe_div_unit u_dut (
      .clk    (clk),
      .rst    (rst),
      .div_if (dif)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain integer division, remainder takes dividend's sign.
   task automatic model(input logic [31:0] a, input logic [31:0] b, input logic sg,
                        output logic [31:0] q, output logic [31:0] r, output int lat);
      longint sa, sb, lq, lr, mag;
      int     n;
      sa = sg ? longint'($signed(a)) : longint'({32'b0, a});
      sb = sg ? longint'($signed(b)) : longint'({32'b0, b});
      if (b == 32'd0) begin
         q   = 32'hFFFF_FFFF;
         r   = a;
         lat = 1;
      end else begin
         lq  = sa / sb;
         lr  = sa % sb;
         q   = lq[31:0];
         r   = lr[31:0];
         mag = (sa < 0) ? -sa : sa;
`ifdef DIV_EARLY_OUT_EN
         n   = $clog2(mag + 1);
         if (n < 1) n = 1;
         lat = n + 1;
`else
         n   = 32;
         lat = 33;
`endif
      end
   endtask

   // Monitor: every done pulse must match the oldest expected result and cycle.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && dif.div_done) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: done=1 with empty scoreboard (cycle %0d)", cyc);
         end else begin
            e = sb_q.pop_front();
            check("quot", dif.div_quot, e.q);
            check("rem", dif.div_rem, e.r);
            check("done_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   // Issue one operation in C0 and track busy until done (or flush).
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sg,
                        input int poke_k, input int flush_k);
      logic [31:0] q, r;
      int          lat, c0;
      bit          got, busy_bad;
      exp_t        e;
      model(a, b, sg, q, r, lat);
      @(posedge clk);
      #1;
      dif.div_start  = 1'b1;
      dif.div_signed = sg;
      dif.div_a      = a;
      dif.div_b      = b;
      c0 = cyc;
      if (flush_k == 0) begin
         e.q = q; e.r = r; e.cyc = c0 + lat;
         sb_q.push_back(e);
      end
      @(negedge clk);
      check("busy_c0", 32'(dif.div_busy), 32'd1);
      @(posedge clk);
      #1;
      dif.div_start = 1'b0;
      dif.div_a     = $urandom;
      dif.div_b     = $urandom;
      got      = 0;
      busy_bad = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (flush_k != 0 && k == flush_k + 1) begin
            dif.div_flush = 1'b0;
            check("busy_after_flush", 32'(dif.div_busy), 32'd0);
            check("done_after_flush", 32'(dif.div_done), 32'd0);
            check("quot_held", dif.div_quot, last_q);
            check("rem_held", dif.div_rem, last_r);
            got = 1;
            break;
         end
         if (dif.div_done) begin
            check("busy_at_done", 32'(dif.div_busy), 32'd0);
            got = 1;
            break;
         end
         if (!dif.div_busy) busy_bad = 1;
         if (k == poke_k) begin
            dif.div_start  = 1'b1;
            dif.div_signed = ~sg;
            dif.div_b      = 32'd3;
         end
         if (poke_k != 0 && k == poke_k + 1) dif.div_start = 1'b0;
         if (flush_k != 0 && k == flush_k) dif.div_flush = 1'b1;
      end
      check("busy_profile", 32'(busy_bad), 32'd0);
      if (!got) begin
         failures++;
         checks++;
         $display("FAIL timeout: no done within 40 cycles for a=%h b=%h", a, b);
      end
      dif.div_start = 1'b0;
      dif.div_flush = 1'b0;
      if (flush_k == 0) begin
         last_q = q;
         last_r = r;
      end
   endtask

   initial begin
      logic [31:0] a, b;
      dif.div_start  = 1'b0;
      dif.div_signed = 1'b0;
      dif.div_a      = '0;
      dif.div_b      = '0;
      dif.div_flush  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(dif.div_busy), 32'd0);
      check("rst_done", 32'(dif.div_done), 32'd0);
      check("rst_quot", dif.div_quot, 32'd0);
      check("rst_rem", dif.div_rem, 32'd0);
      rst = 1'b0;

      do_op(32'd100, 32'd7, 1'b0, 0, 0);
      do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 0);
      do_op(32'd7, 32'hFFFF_FFFE, 1'b1, 0, 0);
      do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0);
      do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0, 0);
      do_op(32'h0000_1234, 32'd0, 1'b0, 0, 0);
      do_op(32'h8000_0000, 32'h8000_0001, 1'b0, 0, 0);
      do_op(32'd0, 32'd5, 1'b1, 0, 0);
      // Start requests while busy must be ignored.
      do_op(32'hDEAD_BEEF, 32'd13, 1'b0, 5, 0);
      // Flush in C10 aborts; next start lands in C12.
      do_op(32'd100, 32'd7, 1'b0, 0, 10);
      do_op(32'd9, 32'd3, 1'b0, 0, 0);

      // Start together with flush: nothing starts.
      @(posedge clk);
      #1;
      dif.div_start = 1'b1;
      dif.div_flush = 1'b1;
      dif.div_a     = 32'd50;
      dif.div_b     = 32'd5;
      @(negedge clk);
      check("start_flush_busy", 32'(dif.div_busy), 32'd0);
      @(posedge clk);
      #1;
      dif.div_start = 1'b0;
      dif.div_flush = 1'b0;
      @(negedge clk);
      check("start_flush_idle", 32'(dif.div_busy), 32'd0);
      repeat (3) @(negedge clk);
      check("start_flush_no_done", 32'(dif.div_done), 32'd0);

      // Asynchronous reset in the middle of an operation.
      @(posedge clk);
      #1;
      dif.div_start  = 1'b1;
      dif.div_signed = 1'b0;
      dif.div_a      = 32'd1000;
      dif.div_b      = 32'd7;
      @(posedge clk);
      #1;
      dif.div_start = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("arst_quot", dif.div_quot, 32'd0);
      check("arst_rem", dif.div_rem, 32'd0);
      check("arst_busy", 32'(dif.div_busy), 32'd0);
      check("arst_done", 32'(dif.div_done), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      last_q = '0;
      last_r = '0;
      repeat (2) @(negedge clk);
      check("arst_idle", 32'(dif.div_busy), 32'd0);

      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         case ($urandom_range(0, 5))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 15));
            2:       b = 32'hFFFF_FFFF;
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
         do_op(a, b, 1'($urandom_range(0, 1)), 0, 0);
      end

      for (int k = 0; k < 50 && sb_q.size() != 0; k++) @(posedge clk);
      if (sb_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain: %0d results still expected", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/exe_div_unit.md
Name: exe_div_unit

Overview:
- Multi-cycle radix-2 restoring divider in the EXE stage, consuming the operands the ID/EXE pipeline register produces (EXE_BusA/EXE_BusB after forwarding).
- Serves OP_DIV and OP_DIVU. Holds the pipeline via a stall while iterating.
- Delivers quotient/remainder as LO/HI write data towards EXE/MEM.
- Can be aborted by the pipeline flush used for exceptions.

Parameters:
- DATA_W, 32, operand/result width; only 32 is required to be supported.
- DIV_ITER, 32, number of iterations for a full-width divide; must equal DATA_W.

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  asynchronous, active-high reset.
- div_start  input  1  EXE holds a DIV/DIVU and is not stalled by others; sampled only in IDLE.
- div_signed  input  1  1 = DIV (two's complement), 0 = DIVU.
- div_a  input  DATA_W  dividend (forwarded rs).
- div_b  input  DATA_W  divisor (forwarded rt).
- div_flush  input  1  abort (IDEXE_Flush / exception); highest priority.
- div_busy  output  1  stall request to PC/IF_ID/ID_EXE write enables.
- div_done  output  1  one-cycle pulse; results valid.
- div_quot  output  DATA_W  quotient (to LO).
- div_rem  output  DATA_W  remainder (to HI).

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, div_busy=0, div_done=0, div_quot=0, div_rem=0, iteration counter=0.
- States: IDLE, BUSY, DONE.
  - IDLE -> BUSY: div_start=1, div_flush=0, div_b!=0.
  - IDLE -> DONE: div_start=1, div_flush=0, div_b==0.
  - BUSY -> DONE: counter reaches DIV_ITER-1.
  - BUSY -> IDLE: div_flush=1.
  - DONE -> IDLE: unconditional.
- Operand latch at start: |a| and |b| (absolute value when div_signed), sign_q = a[31]^b[31], sign_r = a[31]; all signs forced to 0 when unsigned.
- Iteration: 64-bit {rem,quot} shifts left 1; if rem_hi >= |b|, subtract and set quot bit 0.
- Finish correction:
  - quot negated if sign_q.
  - rem negated if sign_r (remainder takes the dividend's sign).
  - Results registered on entry to DONE.
- Latency (start high in cycle C0):
  - div_busy is combinationally high in C0 (= IDLE & div_start & !div_flush) and in C1..C32 (BUSY).
  - div_done is high in C33, and div_busy is low in C33.
- div_done is high only in DONE. div_quot/div_rem hold their values until the next DONE entry.
- Divide by zero: quot = 32'hFFFFFFFF, rem = div_a (raw, uncorrected); done in C1; no exception.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quot = 0x80000000, rem = 0, with no special path.
- div_start while BUSY or DONE is ignored.
- div_flush in any state returns to IDLE next edge with no div_done pulse. Outputs keep their old values.
- div_flush together with div_start in IDLE: no start.
- rst mid-operation: immediate IDLE and the reset values above.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined:
  - At start, compute n = max(1, 32 - clz(|a|)).
  - Pre-shift |a| left by 32-n and run n iterations.
  - div_done occurs in C(n+1). div_a=0 gives done in C2.
- Undefined: fixed 32 iterations; done in C33.
- Results are identical either way.

Decomposition:
- Shared package/header (alongside the CPU defines):
  - enum DivStateType {DIV_IDLE, DIV_BUSY, DIV_DONE}.
  - constant DIV_ITER.
  - struct DivResultType {quot, rem}.
- One sub-module, div_clz32: combinational leading-zero count of |a|, instantiated only under DIV_EARLY_OUT_EN.
- Iteration datapath stays inline.

Test Plan:
- Unsigned 100 / 7, start in C0 -> busy C0..C32, done C33 only, quot=14, rem=2 (macro off).
- Signed 0xFFFFFFF9 (-7) / 2 -> quot=0xFFFFFFFD, rem=0xFFFFFFFF. Signed 7 / -2 -> quot=0xFFFFFFFD, rem=1.
- Signed 0x80000000 / 0xFFFFFFFF -> quot=0x80000000, rem=0. DIVU 0xFFFFFFFF / 1 -> quot=0xFFFFFFFF, rem=0.
- Divide by zero: div_a=0x1234, div_b=0 -> done in C1, quot=0xFFFFFFFF, rem=0x1234.
- Flush and start:
  - div_flush in C10 -> no done, busy low from C11.
  - New 9/3 start in C12 -> done C45, quot=3, rem=0.
  - Start+flush same cycle -> busy 0, no operation.
- rst asserted asynchronously mid-BUSY -> outputs zero immediately, state IDLE.
- With DIV_EARLY_OUT_EN: 100 / 7 -> n=7, done C8, same results.
